// File: rtl/regdst_pipe_pkg.sv
// Shared types and defaults for the register-destination pipeline.
package regdst_pipe_pkg;

  localparam int unsigned DEF_AW       = 5;
  localparam int unsigned DEF_STAGES   = 3;
  localparam int unsigned DEF_LINK_REG = 31;

  typedef enum logic [1:0] {
    SEL_RT   = 2'b00,
    SEL_RD   = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } regdst_sel_e;

  // Entry layout at the default address width; the top rebuilds it at its own AW.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [DEF_AW-1:0] dst;
  } dst_entry_t;

endpackage

// File: rtl/regdst_stage_reg.sv
// One pipeline stage holding {valid, we, dst}; load wins over clear, clear keeps dst.
module regdst_stage_reg #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_dst,
  output logic          q_valid,
  output logic          q_we,
  output logic [AW-1:0] q_dst
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_we    <= 1'b0;
      q_dst   <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_we    <= d_we;
      q_dst   <= d_dst;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_we    <= 1'b0;
    end
  end

endmodule

// File: rtl/regdst_pipe.sv
// Destination select (RT/RD/LINK) plus STAGES-deep {valid,we,dst} pipe with forwarding select.
// Optional perf counters enabled by defining REGDST_PIPE_PERF_EN.
module regdst_pipe
  import regdst_pipe_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned STAGES   = DEF_STAGES,
  parameter int unsigned LINK_REG = DEF_LINK_REG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   sel,
  input  logic [AW-1:0]                rt,
  input  logic [AW-1:0]                rd,
  input  logic                         reg_write_in,
  input  logic                         valid_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [AW-1:0]                src_a,
  input  logic [AW-1:0]                src_b,
  output logic [STAGES*AW-1:0]         stage_dst,
  output logic [STAGES-1:0]            stage_we,
  output logic [AW-1:0]                wb_dst,
  output logic                         wb_we,
  output logic [$clog2(STAGES+1)-1:0]  fwd_sel_a,
  output logic [$clog2(STAGES+1)-1:0]  fwd_sel_b
`ifdef REGDST_PIPE_PERF_EN
  ,
  output logic [15:0]                  perf_wr_cnt,
  output logic [15:0]                  perf_bubble_cnt
`endif
);

  localparam int unsigned FW = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("regdst_pipe: STAGES must be within 1..8");
  end
  if ((64'(LINK_REG) >> AW) != 64'd0) begin : g_bad_link
    $error("regdst_pipe: LINK_REG does not fit in AW bits");
  end

  logic [AW-1:0] dst_new;
  logic          we_new;

  always_comb begin
    dst_new = rt;
    case (regdst_sel_e'(sel))
      SEL_RD:   dst_new = rd;
      SEL_LINK: dst_new = AW'(LINK_REG);
      default:  dst_new = rt;
    endcase
    we_new = valid_in & reg_write_in & (dst_new != '0);
  end

  logic          in_valid [STAGES];
  logic          in_we    [STAGES];
  logic [AW-1:0] in_dst   [STAGES];
  logic          q_valid  [STAGES];
  logic          q_we     [STAGES];
  logic [AW-1:0] q_dst    [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign in_valid[k] = valid_in & ~flush;
      assign in_we[k]    = we_new & ~flush;
      assign in_dst[k]   = dst_new;
    end else begin : g_rest
      assign in_valid[k] = q_valid[k-1];
      assign in_we[k]    = q_we[k-1];
      assign in_dst[k]   = q_dst[k-1];
    end

    // Only stage 1 honours the stalled flush; older stages simply hold.
    regdst_stage_reg #(.AW(AW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (~stall),
      .clear   ((k == 0) ? (stall & flush) : 1'b0),
      .d_valid (in_valid[k]),
      .d_we    (in_we[k]),
      .d_dst   (in_dst[k]),
      .q_valid (q_valid[k]),
      .q_we    (q_we[k]),
      .q_dst   (q_dst[k])
    );

    assign stage_dst[k*AW +: AW] = q_dst[k];
    assign stage_we[k]           = q_we[k];
  end

  assign wb_dst = q_dst[STAGES-1];
  assign wb_we  = q_we[STAGES-1];

  // Scan oldest to youngest so the youngest hit is the one left standing.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int unsigned i = STAGES; i > 0; i--) begin
      if (q_we[i-1] && (q_dst[i-1] == src_a) && (src_a != '0)) fwd_sel_a = FW'(i);
      if (q_we[i-1] && (q_dst[i-1] == src_b) && (src_b != '0)) fwd_sel_b = FW'(i);
    end
  end

`ifdef REGDST_PIPE_PERF_EN
  logic bubble_load;
  assign bubble_load = stall ? flush : ~(valid_in & ~flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wr_cnt     <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (wb_we && !stall) perf_wr_cnt <= perf_wr_cnt + 16'd1;
      if (bubble_load) perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regdst_pipe.sv
// Directed self-checking bench for regdst_pipe at AW=5, STAGES=3, LINK_REG=31.
module tb_regdst_pipe;

  localparam int unsigned AW = 5;
  localparam int unsigned ST = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sel;
  logic [AW-1:0] rt, rd, src_a, src_b;
  logic          reg_write_in, valid_in, stall, flush;
  logic [ST*AW-1:0] stage_dst;
  logic [ST-1:0]    stage_we;
  logic [AW-1:0]    wb_dst;
  logic             wb_we;
  logic [1:0]       fwd_sel_a, fwd_sel_b;
`ifdef REGDST_PIPE_PERF_EN
  logic [15:0] perf_wr_cnt, perf_bubble_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regdst_pipe #(.AW(AW), .STAGES(ST), .LINK_REG(31)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .rt           (rt),
    .rd           (rd),
    .reg_write_in (reg_write_in),
    .valid_in     (valid_in),
    .stall        (stall),
    .flush        (flush),
    .src_a        (src_a),
    .src_b        (src_b),
    .stage_dst    (stage_dst),
    .stage_we     (stage_we),
    .wb_dst       (wb_dst),
    .wb_we        (wb_we),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b)
`ifdef REGDST_PIPE_PERF_EN
    ,
    .perf_wr_cnt     (perf_wr_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'b00; rt = '0; rd = '0; src_a = '0; src_b = '0;
    reg_write_in = 1'b0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    step(); step();
    chk("reset_stage_we",  32'(stage_we),  32'd0);
    chk("reset_stage_dst", 32'(stage_dst), 32'd0);
    chk("reset_wb",        32'({wb_we, wb_dst}), 32'd0);
    rst_n = 1'b1;

    // Mode select: RD, LINK, reserved->RT
    valid_in = 1'b1; reg_write_in = 1'b1; sel = 2'b01; rt = 5'd3; rd = 5'd7;
    step();
    chk("sel_rd_s1", 32'(stage_dst[4:0]), 32'd7);
    chk("sel_rd_we", 32'(stage_we), 32'b001);
    sel = 2'b10;
    step();
    chk("sel_link_s1", 32'(stage_dst[4:0]), 32'd31);
    sel = 2'b11;
    step();
    chk("sel_rsvd_pipe", 32'(stage_dst), 32'({5'd7, 5'd31, 5'd3}));
    chk("wb_rd", 32'({wb_we, wb_dst}), 32'({1'b1, 5'd7}));
    valid_in = 1'b0; sel = 2'b00; rt = 5'd0;
    step();
    chk("wb_link", 32'({wb_we, wb_dst}), 32'({1'b1, 5'd31}));
    step();
    chk("wb_rsvd", 32'({wb_we, wb_dst}), 32'({1'b1, 5'd3}));

    // Zero register writes are squashed all the way down
    valid_in = 1'b1; reg_write_in = 1'b1; sel = 2'b00; rt = 5'd0;
    step(); step(); step();
    chk("zero_we", 32'(stage_we), 32'd0);
    chk("zero_fwd", 32'(fwd_sel_a), 32'd0);

    // Forward priority
    sel = 2'b01; rd = 5'd9; src_a = 5'd9; src_b = 5'd5;
    step(); step();
    chk("fwd_young", 32'(fwd_sel_a), 32'd1);
    chk("fwd_miss_b", 32'(fwd_sel_b), 32'd0);
    valid_in = 1'b0;
    step();
    chk("fwd_after_bubble", 32'(fwd_sel_a), 32'd2);
    src_a = 5'd0; #1;
    chk("fwd_src0", 32'(fwd_sel_a), 32'd0);

    // Stall / flush
    valid_in = 1'b1; rd = 5'd4; step();
    rd = 5'd5; step();
    rd = 5'd6; step();
    chk("pre_stall_dst", 32'(stage_dst), 32'({5'd4, 5'd5, 5'd6}));
    stall = 1'b1; rd = 5'd10;
    step(); step();
    chk("stall_dst", 32'(stage_dst), 32'({5'd4, 5'd5, 5'd6}));
    chk("stall_we",  32'(stage_we),  32'b111);
    flush = 1'b1;
    step();
    chk("stflush_we",  32'(stage_we),  32'b110);
    chk("stflush_dst", 32'(stage_dst), 32'({5'd4, 5'd5, 5'd6}));
    stall = 1'b0; flush = 1'b0; rd = 5'd11;
    step();
    chk("resume_dst", 32'(stage_dst), 32'({5'd5, 5'd6, 5'd11}));
    chk("resume_we",  32'(stage_we),  32'b101);
    src_a = 5'd6; src_b = 5'd5; #1;
    chk("fwd_flushed", 32'(fwd_sel_a), 32'd0);
    chk("fwd_wb",      32'(fwd_sel_b), 32'd3);

    // Asynchronous reset with entries in flight
    src_a = 5'd11;
    rst_n = 1'b0; #2;
    chk("async_rst_we",  32'(stage_we),  32'd0);
    chk("async_rst_wb",  32'(wb_dst),    32'd0);
    chk("async_rst_fwd", 32'(fwd_sel_a), 32'd0);
    chk("async_rst_dst", 32'(stage_dst), 32'd0);
    valid_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_we", 32'(stage_we), 32'd0);

`ifdef REGDST_PIPE_PERF_EN
    rst_n = 1'b0; #2;
    chk("perf_rst", 32'({perf_wr_cnt, perf_bubble_cnt}), 32'd0);
    step();
    valid_in = 1'b1; reg_write_in = 1'b1; sel = 2'b01; rd = 5'd1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    step(); step();
    flush = 1'b0; reg_write_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("perf_wr",     32'(perf_wr_cnt),     32'd5);
    chk("perf_bubble", 32'(perf_bubble_cnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the 2:1 RT/RD destination mux.
- Selects the write-destination register from RT, RD or a fixed link register (JAL/JALR), then carries {valid, we, dst} down a STAGES-deep pipeline (EX..WB).
- Exposes per-stage destinations plus a priority forwarding select for two source operands.
- Sits beside the ID/EX register and feeds the forwarding unit and register-file write port.

Parameters:
- AW, 5, register-address width.
- STAGES, 3, pipeline depth tracked (stage 1 = youngest/EX, stage STAGES = WB); legal 1..8.
- LINK_REG, 31, destination forced in LINK mode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  2  00=RT, 01=RD, 10=LINK, 11=reserved (treated as RT)
- rt  in  AW  RT field
- rd  in  AW  RD field
- reg_write_in  in  1  instruction writes a register
- valid_in  in  1  instruction present in ID
- stall  in  1  freeze whole pipe
- flush  in  1  kill the instruction entering stage 1
- src_a, src_b  in  AW  source register addresses being read in ID
- stage_dst  out  STAGES*AW  flattened per-stage dst, stage 1 in LSBs
- stage_we  out  STAGES  per-stage effective write enable
- wb_dst  out  AW  stage STAGES dst
- wb_we  out  1  stage STAGES write enable
- fwd_sel_a, fwd_sel_b  out  $clog2(STAGES+1)  0 = no hit; k = youngest matching stage k

Behaviour:
- Reset (async, rst_n low): every stage valid=0, we=0, dst=0; all outputs 0. Reset mid-operation discards in-flight entries immediately; no partial shift on the release edge.
- Select (combinational):
  - dst_new = rt | rd | LINK_REG per sel.
  - we_new = valid_in & reg_write_in & (dst_new != 0); writes to register 0 are squashed.
- Shift, when stall=0 on each clk edge: stage1 <= {valid_in & ~flush, we_new & ~flush, dst_new}; stage k <= stage k-1.
- stall=1: all stages hold.
- stall=1 & flush=1: stage 1 is cleared (valid=0, we=0, dst held); stages 2..STAGES hold.
- Latency: selected dst appears on stage_dst[stage1] one cycle after capture and on wb_dst STAGES cycles later, absent stalls.
- Forwarding (combinational from registered state):
  - fwd_sel_x = smallest k with stage_we[k] & stage_dst[k]==src_x & src_x!=0; else 0.
  - Multiple hits resolve to the youngest stage.
  - src_x==0 always yields 0.
- stage_we[k] = stored we (already includes valid); outputs are registers only, no input-to-output paths except fwd_sel.
- Width rules: no truncation; LINK_REG must fit in AW bits. Elaboration error if not, or if STAGES is outside 1..8.

Optional Feature:
- REGDST_PIPE_PERF_EN defined:
  - Adds outputs perf_wr_cnt[15:0] (increments when wb_we=1 and stall=0) and perf_bubble_cnt[15:0] (increments when stage 1 is loaded with valid=0, including flush).
  - Both counters wrap at 16'hFFFF to 0 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package regdst_pipe_pkg:
  - enum regdst_sel_e {SEL_RT, SEL_RD, SEL_LINK, SEL_RSVD};
  - parameterised struct dst_entry_t {valid, we, dst} (via AW-typed localparam);
  - default LINK_REG constant.
- Sub-module regdst_stage_reg: one stage register with hold/clear/load controls, instantiated STAGES times via generate.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 entries in flight -> all stage_we=0, wb_dst=0, fwd_sel_a=0 immediately, without waiting for a clock edge.
- Mode select: sel=01, rd=7, rt=3, reg_write_in=1 -> stage 1 dst=7; sel=10 -> stage 1 dst=31; sel=11, rt=3 -> dst=3. Each reaches wb_dst 3 cycles later.
- Zero register: sel=00, rt=0, reg_write_in=1 -> stage_we all 0 through the pipe; src_a=0 -> fwd_sel_a=0.
- Forward priority: load dst=9 in two consecutive cycles, src_a=9 -> fwd_sel_a=1; after a further bubble cycle -> fwd_sel_a=2.
- Stall/flush: stall=1 for 2 cycles -> stage contents unchanged; stall=1 & flush=1 -> stage 1 we=0, stage 2 unchanged; flush=0 & stall=0 resumes shifting.
- Perf (macro on): 5 writes plus 2 flushes -> perf_wr_cnt=5, perf_bubble_cnt=2; preload perf_wr_cnt to 16'hFFFF -> wraps to 0 on the next write.
